// File: rtl/serial_deserializer.sv
// -----------------------------------------------------------------------------
// serial_deserializer
//
// Receive end of the start-strobed, LSB-first serial link. A one-cycle start
// strobe opens a frame. The first data bit arrives on rx in the next cycle, and
// one bit is sampled per clock after that. When the word is complete it is
// committed into a single-entry valid/ready output buffer.
//
// Optional feature (compile-time macro SERIAL_DESER_PARITY_EN):
//   When the macro is defined, one even-parity bit follows the data bits. It is
//   sampled in a PARITY state. parity_err is registered together with the word.
//   When the macro is not defined, the frame holds only the data bits and
//   parity_err is tied low.
//
// Parameters
//   WIDTH      data bits per frame (>= 2)
//   CNT_W      bit-counter width, derived from WIDTH (leave at default)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-high reset
//   start       in   frame strobe; first data bit follows next cycle
//   rx          in   serial data, LSB first
//   data_out    out  received word, held while data_valid=1
//   data_valid  out  data_out holds an unconsumed word
//   data_ready  in   consumer accept; transfer on data_valid & data_ready
//   busy        out  frame in progress (state != IDLE)
//   bit_count   out  data bits captured so far in the current frame
//   overrun     out  sticky: a completed frame was dropped (buffer full)
//   parity_err  out  parity mismatch on the word in data_out
//
// Handshake: a word transfers to the consumer on each rising edge where
// data_valid and data_ready are both 1. data_out and parity_err hold steady
// while data_valid=1 and no transfer happens. If data_ready=1 while
// data_valid=0, the input is ignored.
// -----------------------------------------------------------------------------
module serial_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             rx,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SERIAL_DESER_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] word;
  logic             last_data;
  logic             commit;
  logic             accept;
  logic             consume;

  // Word as it stands after this edge's sample. rx goes straight into its bit
  // position. That way the commit edge can load the complete word into
  // data_out without waiting for one more cycle.
  always_comb begin
    word = shreg;
    if (state == SHIFT) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bit_count == CNT_W'(i)) begin
          word[i] = rx;
        end
      end
    end
  end

  assign last_data = (state == SHIFT) && (bit_count == LAST_BIT);

`ifdef SERIAL_DESER_PARITY_EN
  logic perr_q;
  logic parity_calc;

  // Even parity over the data bits and the parity bit that rx carries now.
  assign parity_calc = (^shreg) ^ rx;
  assign commit      = (state == PARITY);
  assign parity_err  = perr_q;
`else
  assign commit      = last_data;
  assign parity_err  = 1'b0;
`endif

  assign consume = data_valid & data_ready;
  // The buffer can take a new word if it is empty or is being emptied on this edge.
  assign accept  = ~data_valid | data_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_count  <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      // ---------------- frame sequencing ----------------
      case (state)
        IDLE: begin
          // Stay idle. bit_count keeps its last value, so it still reads
          // WIDTH after a completed frame.
        end
        SHIFT: begin
          shreg     <= word;
          bit_count <= bit_count + CNT_ONE;
          if (last_data) begin
`ifdef SERIAL_DESER_PARITY_EN
            state <= PARITY;
`else
            state <= IDLE;
`endif
          end
        end
`ifdef SERIAL_DESER_PARITY_EN
        PARITY: begin
          state <= IDLE;
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase

      // A start strobe overrides the sequencing above. Before the commit edge
      // it aborts the frame and reloads the counter at bit 0. On the commit
      // edge the frame still commits below, and the next frame starts with no
      // gap.
      if (start) begin
        state     <= SHIFT;
        bit_count <= '0;
        shreg     <= '0;
      end

      // ---------------- output buffer ----------------
      if (commit) begin
        if (accept) begin
          data_out   <= word;
          data_valid <= 1'b1;
`ifdef SERIAL_DESER_PARITY_EN
          perr_q     <= parity_calc;
`endif
        end else begin
          // Buffer full and not draining: drop the word and keep the old one.
          overrun <= 1'b1;
        end
      end else if (consume) begin
        data_valid <= 1'b0;
`ifdef SERIAL_DESER_PARITY_EN
        perr_q     <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_deserializer.sv
// -----------------------------------------------------------------------------
// tb_serial_deserializer
//
// Checks serial_deserializer (WIDTH=4) against a reference model. The model
// works at frame level: it keeps a queue of the bits received since the last
// start, plus one buffer-occupied flag. Every word the model accepts goes into
// exp_q. The monitor runs on each falling edge. It compares the status outputs
// with the model, checks data_out/parity_err against the head of exp_q, and
// pops that entry whenever a transfer is about to happen.
// -----------------------------------------------------------------------------
module tb_serial_deserializer;

  localparam int WIDTH = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef SERIAL_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic             rx = 1'b0;
  logic             data_ready = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;
  logic             parity_err;

  always #5 clk = ~clk;

  serial_deserializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .rx         (rx),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .bit_count  (bit_count),
    .overrun    (overrun),
    .parity_err (parity_err)
  );

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  logic [WIDTH:0]   exp_q[$];     // {parity_err, word} accepted into the buffer
  logic [WIDTH-1:0] got_log[$];   // words seen leaving the DUT
  bit               bits_q[$];
  bit               in_frame;
  bit               m_valid;
  bit               m_over;
  int               m_last;
  bit               mon_en = 1'b0;
  bit               m_commit;
  logic [WIDTH-1:0] m_word;
  logic             m_perr;

  always @(posedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      bits_q.delete();
      m_valid  = 1'b0;
      m_over   = 1'b0;
      m_last   = 0;
      exp_q.delete();
      mon_en   = 1'b1;
    end else begin
      m_commit = 1'b0;
      if (in_frame) begin
        bits_q.push_back(rx);
        if (bits_q.size() == FRAME_LEN) m_commit = 1'b1;
      end
      if (m_commit) begin
        m_word = '0;
        m_perr = 1'b0;
        for (int i = 0; i < WIDTH; i++) m_word[i] = bits_q[i];
`ifdef SERIAL_DESER_PARITY_EN
        foreach (bits_q[i]) m_perr = m_perr ^ bits_q[i];
`endif
        if (!m_valid || data_ready) begin
          exp_q.push_back({m_perr, m_word});
          m_valid = 1'b1;
        end else begin
          m_over = 1'b1;
        end
        in_frame = 1'b0;
        m_last   = WIDTH;
      end else if (m_valid && data_ready) begin
        m_valid = 1'b0;
      end
      if (start) begin
        in_frame = 1'b1;
        bits_q.delete();
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      check("busy", 32'(busy), 32'(in_frame));
      check("bit_count", 32'(bit_count), in_frame ? bits_q.size() : m_last);
      check("data_valid", 32'(data_valid), 32'(m_valid));
      check("overrun", 32'(overrun), 32'(m_over));
      if (m_valid && exp_q.size() > 0) begin
        check("data_out", 32'(data_out), 32'(exp_q[0][WIDTH-1:0]));
        check("parity_err", 32'(parity_err), 32'(exp_q[0][WIDTH]));
      end else begin
        check("parity_err_idle", 32'(parity_err), 32'(0));
      end
      if (data_valid && data_ready && !reset) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_transfer: got %0h expected none", data_out);
        end else begin
          void'(exp_q.pop_front());
          got_log.push_back(data_out);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  int rdy_mode = 0;  // 0: hold low, 1: hold high, 2: random

  task automatic drive(input logic s, input logic r);
    start = s;
    rx    = r;
    if (rdy_mode == 2) data_ready = 1'($urandom_range(0, 1));
    else               data_ready = (rdy_mode == 1);
    @(posedge clk);
    #1;
  endtask

  // Data bits LSB first, then parity bit if enabled. chain puts start on the commit edge.
  task automatic send_bits(input logic [WIDTH-1:0] w, input logic pbit, input bit chain);
    logic fb[FRAME_LEN];
    for (int i = 0; i < WIDTH; i++) fb[i] = w[i];
    if (FRAME_LEN > WIDTH) fb[FRAME_LEN-1] = pbit;
    for (int i = 0; i < FRAME_LEN; i++) drive(chain && (i == FRAME_LEN - 1), fb[i]);
  endtask

  task automatic frame(input logic [WIDTH-1:0] w);
    drive(1'b1, 1'b0);
    send_bits(w, ^w, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic drain();
    rdy_mode = 1;
    idle(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid", 32'(data_valid), 32'(0));
    check("reset_data", 32'(data_out), 32'(0));
    reset = 1'b0;
    idle(2);

    // Basic frame, consumer stalled
    rdy_mode = 0;
    frame(4'b1101);
    check("t1_data", 32'(data_out), 32'hD);
    check("t1_valid", 32'(data_valid), 32'(1));
    idle(1);
    check("t1_busy", 32'(busy), 32'(0));
    check("t1_count", 32'(bit_count), WIDTH);
    drain();

    // Back-to-back frames, start on commit edge
    got_log.delete();
    rdy_mode = 1;
    drive(1'b1, 1'b0);
    send_bits(4'hA, ^4'hA, 1'b1);
    send_bits(4'h5, ^4'h5, 1'b0);
    idle(3);
    check("t2_count", got_log.size(), 2);
    if (got_log.size() == 2) begin
      check("t2_first", 32'(got_log[0]), 32'hA);
      check("t2_second", 32'(got_log[1]), 32'h5);
    end
    check("t2_overrun", 32'(overrun), 32'(0));

    // Overrun
    rdy_mode = 0;
    frame(4'h3);
    frame(4'hC);
    check("t3_data", 32'(data_out), 32'h3);
    check("t3_overrun", 32'(overrun), 32'(1));
    drain();
    check("t3_sticky", 32'(overrun), 32'(1));

    // Reset mid-frame
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    reset = 1'b1;
    drive(1'b0, 1'b1);
    check("t5_data", 32'(data_out), 32'(0));
    check("t5_busy", 32'(busy), 32'(0));
    check("t5_count", 32'(bit_count), 32'(0));
    check("t5_overrun", 32'(overrun), 32'(0));
    reset = 1'b0;
    rdy_mode = 0;
    frame(4'h9);
    check("t5_after", 32'(data_out), 32'h9);
    drain();

    // Restart mid-frame
    got_log.delete();
    rdy_mode = 0;
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b1);
    drive(1'b0, 1'b1);
    frame(4'b0100);
    check("t4_data", 32'(data_out), 32'h4);
    drain();
    check("t4_single", got_log.size(), 1);

`ifdef SERIAL_DESER_PARITY_EN
    rdy_mode = 0;
    drive(1'b1, 1'b0);
    send_bits(4'b0111, 1'b1, 1'b0);
    check("t6_ok", 32'(parity_err), 32'(0));
    drain();
    rdy_mode = 0;
    drive(1'b1, 1'b0);
    send_bits(4'b0111, 1'b0, 1'b0);
    check("t6_err", 32'(parity_err), 32'(1));
    check("t6_data", 32'(data_out), 32'h7);
    drain();
`endif

    // Random traffic
    rdy_mode = 2;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        reset = 1'b0;
      end else begin
        drive($urandom_range(0, 99) < 12, 1'($urandom_range(0, 1)));
      end
    end
    rdy_mode = 1;
    idle(FRAME_LEN + 4);
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
